// File: rtl/blur_pkg.sv
// Shared constants, read-FSM state type and buffer-index arithmetic for the
// Gaussian-blur line-buffer scheduler.
package blur_pkg;

  localparam int unsigned IMG_W = 640;
  localparam int unsigned IMG_H = 480;
  localparam int unsigned N_BUF = 6;
  localparam int unsigned WIN   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRead
  } rd_state_e;

  // (a + b) mod N_BUF for operands already below N_BUF.
  function automatic logic [2:0] buf_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'(N_BUF)) ? 3'(s - 4'(N_BUF)) : s[2:0];
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Counter 0..MAX with synchronous clear; clr and inc in the same cycle count
// from zero, so a clearing event can also consume the first increment.
module wrap_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d, base;

  always_comb begin
    base    = clr ? '0 : value_q;
    wrap    = inc && (base == W'(MAX));
    value_d = base;
    if (inc) value_d = wrap ? '0 : base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/blur_sched.sv
// Line-buffer bank scheduler: steers incoming pixels into six row buffers and
// issues five-row window column reads with border masks.
module blur_sched #(
  parameter int unsigned IMG_W = blur_pkg::IMG_W,
  parameter int unsigned IMG_H = blur_pkg::IMG_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       in_en,
  input  logic       out_ready,
  output logic [5:0] wr_buff_en,
  output logic [9:0] wr_addr,
  output logic [5:0] rd_buff_en,
  output logic [9:0] rd_addr,
  output logic [2:0] rd_base,
  output logic [4:0] row_mask,
  output logic       out_valid,
  output logic [8:0] out_row,
  output logic [9:0] out_col,
  output logic       frame_done,
  output logic       overflow
);
  import blur_pkg::*;

  rd_state_e  state_q;
  logic       armed_q, overflow_q;
  logic [9:0] rows_written_q, rows_need;
  logic [2:0] wbuf_q, wbuf_cur, rbuf_q, base;
  logic [9:0] wcol, wcol_cur, rcol, r_ext;
  logic [8:0] wrow, wrow_cur, r;
  logic       wcol_wrap, wrow_wrap, rcol_wrap, r_wrap;
  logic       accept, issue, rd_act;
  logic [4:0] mask;
  logic [5:0] en;
  logic       out_valid_q, frame_done_q;
  logic [8:0] out_row_q;
  logic [9:0] out_col_q;

  // A frame_start pixel is pixel (0,0) of the new frame, so views restart at zero.
  assign accept   = in_en & ~rst & (frame_start | armed_q);
  assign wcol_cur = frame_start ? '0 : wcol;
  assign wrow_cur = frame_start ? '0 : wrow;
  assign wbuf_cur = frame_start ? '0 : wbuf_q;
  assign issue    = (state_q == StRead) & out_ready & ~frame_start;
  assign r_ext    = {1'b0, r};

  wrap_counter #(.MAX(IMG_W - 1), .W(10)) u_wcol (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(accept), .value(wcol), .wrap(wcol_wrap)
  );
  wrap_counter #(.MAX(IMG_H - 1), .W(9)) u_wrow (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(wcol_wrap), .value(wrow), .wrap(wrow_wrap)
  );
  wrap_counter #(.MAX(IMG_W - 1), .W(10)) u_rcol (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(issue), .value(rcol), .wrap(rcol_wrap)
  );
  wrap_counter #(.MAX(IMG_H - 1), .W(9)) u_r (
    .clk(clk), .rst(rst), .clr(frame_start), .inc(rcol_wrap), .value(r), .wrap(r_wrap)
  );

  always_comb begin
    rows_need = ((r_ext + 10'd3) > 10'(IMG_H)) ? 10'(IMG_H) : r_ext + 10'd3;
    rd_act    = (state_q == StRead);
    base      = buf_add(rbuf_q, 3'd4);
    mask      = {(r_ext + 10'd2) < 10'(IMG_H), (r_ext + 10'd1) < 10'(IMG_H), 1'b1,
                 r != 9'd0, r > 9'd1};
    en        = '0;
    for (int unsigned k = 0; k < WIN; k++) begin
      if (mask[k]) en = en | (6'd1 << buf_add(base, 3'(k)));
    end
    rd_base    = rd_act ? base : '0;
    row_mask   = rd_act ? mask : '0;
    rd_buff_en = rd_act ? en : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      armed_q        <= 1'b0;
      overflow_q     <= 1'b0;
      rows_written_q <= '0;
      wbuf_q         <= '0;
      rbuf_q         <= '0;
      out_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
    end else begin
      rows_written_q <= (frame_start ? 10'd0 : rows_written_q) + {9'd0, wcol_wrap};
      wbuf_q         <= wcol_wrap ? buf_add(wbuf_cur, 3'd1) : wbuf_cur;
      armed_q        <= (frame_start | armed_q) & ~wrow_wrap;
      // Starting row w aliases the buffer of row w-6 >= r-2, still needed by row r,
      // unless row r's last column is being read this very cycle.
      if (accept && (wcol_cur == '0) && !frame_start && (state_q != StIdle) && !rcol_wrap &&
          ({1'b0, wrow_cur} >= r_ext + 10'd4)) begin
        overflow_q <= 1'b1;
      end
      out_valid_q  <= issue;
      frame_done_q <= r_wrap;
      if (issue) begin
        out_row_q <= r;
        out_col_q <= rcol;
      end
      if (frame_start || r_wrap) rbuf_q <= '0;
      else if (rcol_wrap)        rbuf_q <= buf_add(rbuf_q, 3'd1);
      if (frame_start) begin
        state_q <= StWait;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StWait: if (rows_written_q >= rows_need) state_q <= StRead;
          StRead: if (rcol_wrap) state_q <= r_wrap ? StIdle : StWait;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wr_buff_en = accept ? (6'd1 << wbuf_cur) : 6'd0;
  assign wr_addr    = wcol_cur;
  assign rd_addr    = rcol;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_blur_sched.sv
// Scoreboard bench for blur_sched on a reduced 16x12 image.
module tb_blur_sched;
  localparam int TW = 16;
  localparam int TH = 12;

  logic       clk = 1'b0;
  logic       rst, frame_start, in_en, out_ready;
  logic [5:0] wr_buff_en, rd_buff_en;
  logic [9:0] wr_addr, rd_addr, out_col;
  logic [2:0] rd_base;
  logic [4:0] row_mask;
  logic       out_valid, frame_done, overflow;
  logic [8:0] out_row;

  blur_sched #(.IMG_W(TW), .IMG_H(TH)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_en(in_en), .out_ready(out_ready),
    .wr_buff_en(wr_buff_en), .wr_addr(wr_addr), .rd_buff_en(rd_buff_en), .rd_addr(rd_addr),
    .rd_base(rd_base), .row_mask(row_mask), .out_valid(out_valid), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, pix = 0, done_cnt = 0, first_valid_cyc = -1;
  bit   armed_m = 1'b0;
  int   p_addr = 0, p_base = 0, p_mask = 0, p_en = 0;
  bit   p_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int mask_of(input int row);
    int v = 0;
    for (int k = 0; k < 5; k++) if (row - 2 + k >= 0 && row - 2 + k < TH) v |= 1 << k;
    return v;
  endfunction

  function automatic int en_of(input int row);
    int v = 0;
    for (int k = 0; k < 5; k++) begin
      int rr = row - 2 + k;
      if (rr >= 0 && rr < TH) v |= 1 << (rr % 6);
    end
    return v;
  endfunction

  // Monitor: every presented column must be the next one the frame owes us.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_done) done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_row", int'(out_row), e.row);
        check("out_col", int'(out_col), e.col);
        check("frame_done", int'(frame_done), int'(e.done));
        check("issue_rd_addr", p_addr, e.col);
        check("issue_rd_base", p_base, (e.row + 4) % 6);
        check("issue_row_mask", p_mask, mask_of(e.row));
        check("issue_rd_buff_en", p_en, en_of(e.row));
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", 1, 0);
    end
    if (!p_rdy && p_en != 0 && rd_buff_en != 0) check("rd_addr_hold", int'(rd_addr), p_addr);
    p_addr = int'(rd_addr);
    p_base = int'(rd_base);
    p_mask = int'(row_mask);
    p_en   = int'(rd_buff_en);
    p_rdy  = out_ready;
  end

  // One clock cycle of stimulus, with the write-side reference checked mid-cycle.
  task automatic step(input bit ie, input bit fs, input bit rdy, input bit rs);
    int p;
    bit arm, acc;
    in_en = ie; frame_start = fs; out_ready = rdy; rst = rs;
    p   = fs ? 0 : pix;
    arm = fs | armed_m;
    acc = ie && !rs && arm && (p < TW * TH);
    @(negedge clk);
    check("wr_buff_en", int'(wr_buff_en), acc ? (1 << ((p / TW) % 6)) : 0);
    check("wr_addr", int'(wr_addr), p % TW);
    @(posedge clk);
    #1;
    if (rs) begin
      pix = 0; armed_m = 1'b0; exp_q.delete();
    end else begin
      pix = p + int'(acc); armed_m = arm;
      if (fs) begin
        exp_q.delete();
        for (int r = 0; r < TH; r++)
          for (int c = 0; c < TW; c++)
            exp_q.push_back('{row: r, col: c, done: (r == TH - 1 && c == TW - 1)});
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_buff_en"}, int'(wr_buff_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_rd_buff_en"}, int'(rd_buff_en), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_rd_base"}, int'(rd_base), 0);
    check({tag, "_row_mask"}, int'(row_mask), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_row"}, int'(out_row), 0);
    check({tag, "_out_col"}, int'(out_col), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic drain(input string tag, input bit toggle);
    int n = 0;
    bit tog = 1'b0;
    while (exp_q.size() != 0 && n < 4000) begin
      tog = ~tog;
      step(1'b0, 1'b0, toggle ? tog : 1'b1, 1'b0);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int t_row2, n, d0;
    bit tog;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_all_zero("reset");

    // Frame A: streaming rows with one blank cycle each, downstream always ready.
    first_valid_cyc = -1; done_cnt = 0; t_row2 = 0;
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        if (r == 2 && c == TW - 1) t_row2 = cyc;
        step(1, r == 0 && c == 0, 1, 0);
      end
      step(0, 0, 1, 0);
    end
    drain("frame_a", 1'b0);
    check("first_valid_latency", first_valid_cyc - t_row2, 3);
    check("frame_a_done_count", done_cnt, 1);
    check("frame_a_overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0);

    // Frame B: random input gaps, out_ready alternating.
    done_cnt = 0; n = 0; tog = 1'b0;
    step($urandom_range(0, 2) == 0, 1, 0, 0);
    while (pix < TW * TH && n < 20000) begin
      tog = ~tog;
      step($urandom_range(0, 2) == 0, 0, tog, 0);
      n++;
    end
    drain("frame_b", 1'b1);
    check("frame_b_done_count", done_cnt, 1);

    // Frame C: restart mid-row 5 while reading; the aborted frame owes no frame_done.
    step(0, 0, 0, 1);
    done_cnt = 0; n = 0;
    step($urandom_range(0, 1) == 0, 1, 1, 0);
    while (pix < 5 * TW + TW / 2 && n < 4000) begin
      step($urandom_range(0, 1) == 0, 0, 1, 0);
      n++;
    end
    n = 0;
    while (rd_buff_en == 0 && n < 200) begin
      step(0, 0, 1, 0);
      n++;
    end
    d0 = done_cnt;
    step(1, 1, 1, 0);
    check("abort_no_done", done_cnt, d0);
    while (pix < TW * TH) begin
      step(1, 0, 1, 0);
      if (pix % TW == 0) step(0, 0, 1, 0);
    end
    drain("frame_c", 1'b0);
    check("frame_c_done_count", done_cnt, d0 + 1);

    // Frame D: downstream stalled at r=0 while five rows arrive.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5 * TW; i++) begin
      if (i == 3 * TW || i == 4 * TW) check("overflow_before_row", int'(overflow), 0);
      step(1, i == 0, 0, 0);
      if (i == 4 * TW) check("overflow_at_row4", int'(overflow), 1);
    end
    check("overflow_sticky", int'(overflow), 1);
    step(0, 1, 0, 0);
    check("overflow_survives_frame_start", int'(overflow), 1);
    step(0, 0, 0, 1);
    check_all_zero("rst_after_overflow");

    // Frame E: reset mid-frame, then input must be ignored without frame_start.
    done_cnt = 0;
    step(1, 1, 1, 0);
    for (int i = 0; i < 4 * TW; i++) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    check_all_zero("rst_mid_frame");
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
    check("rst_no_done", done_cnt, 0);
    check("rst_no_reads", int'(rd_buff_en), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
